mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Uses a registered request/ack handshake toward memory, so memory latency can vary.
- Serialises accesses and drives per-port ready and stall signals into the pipeline hazard logic.
- MEM-stage priority prevents a stalled older instruction from being blocked; a bounded starvation counter guarantees forward progress for fetch.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_starve_ctr.sv | 33 +++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/MEM memory port arbiter.
// No logic here; latency and backpressure are defined by the users of these types.
// Holds the FSM state enum, the grant-select enum and the counter width helper.
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int IF_MAX_WAIT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_sel_t;

    // Keeps the starvation counter at least one bit wide when IF_MAX_WAIT is 0.
    function automatic int starve_cnt_w(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants issued while a fetch is waiting.
// Updates one cycle after the grant; force_i is combinational from the count.
// No backpressure: it only observes grants.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int IF_MAX_WAIT = IF_MAX_WAIT_DEF,
    localparam int CNT_W      = starve_cnt_w(IF_MAX_WAIT)
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             gnt_i,
    input  logic             gnt_d,
    input  logic             if_req,
    output logic [CNT_W-1:0] starve_cnt,
    output logic             force_i
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(IF_MAX_WAIT);

    always_ff @(posedge clk) begin
        if (reset_b) begin
            starve_cnt <= '0;
        end else if (gnt_i) begin
            starve_cnt <= '0;
        end else if (gnt_d && if_req && (starve_cnt != MAX_CNT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_i = (starve_cnt >= MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and data (MEM); optional perf counters via MEM_ARB_PERF_CNT_EN.
// Latency: req -> mem_req +1 cycle, ready one cycle after mem_ack, next grant the cycle after ready.
// Backpressure: requests are held as levels; stall = req & ~ready while the other port or memory is busy.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int IF_MAX_WAIT = IF_MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              dm_stall,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_dm_grants,
    output logic [31:0]       perf_wait_cycles,
`endif
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = starve_cnt_w(IF_MAX_WAIT);

    arb_state_t       state;
    gnt_sel_t         gnt_sel;
    logic [CNT_W-1:0] starve_cnt;
    logic             force_i;

    // Data normally wins so an older stalled instruction drains first; fetch wins once starved.
    always_comb begin
        gnt_sel = GNT_NONE;
        if (state == IDLE) begin
            if (if_req && (!dm_req || force_i)) begin
                gnt_sel = GNT_I;
            end else if (dm_req) begin
                gnt_sel = GNT_D;
            end
        end
    end

    mem_arb_starve_ctr #(
        .IF_MAX_WAIT (IF_MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .reset_b    (reset_b),
        .gnt_i      (gnt_sel == GNT_I),
        .gnt_d      (gnt_sel == GNT_D),
        .if_req     (if_req),
        .starve_cnt (starve_cnt),
        .force_i    (force_i)
    );

    always_ff @(posedge clk) begin
        if (reset_b) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_sel == GNT_I) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        state     <= BUSY_I;
                    end else if (gnt_sel == GNT_D) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        state     <= BUSY_D;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                        state    <= DONE;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                        dm_ready <= 1'b1;
                        state    <= DONE;
                    end
                end
                // Requester's req is still high here, so arbitration waits for IDLE.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign if_stall = if_req & ~if_ready;
    assign dm_stall = dm_req & ~dm_ready;

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset_b) begin
            perf_if_grants   <= '0;
            perf_dm_grants   <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (gnt_sel == GNT_I) begin
                perf_if_grants <= perf_if_grants + 32'd1;
            end
            if (gnt_sel == GNT_D) begin
                perf_dm_grants <= perf_dm_grants + 32'd1;
            end
            if (((state == BUSY_I) || (state == BUSY_D)) && !mem_ack) begin
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions, memory model with programmable latency.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_grants;
    logic [31:0] perf_dm_grants;
    logic [31:0] perf_wait_cycles;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .IF_MAX_WAIT (2)
    ) u_dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .dm_stall  (dm_stall),
`ifdef MEM_ARB_PERF_CNT_EN
        .perf_if_grants   (perf_if_grants),
        .perf_dm_grants   (perf_dm_grants),
        .perf_wait_cycles (perf_wait_cycles),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_if;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    bit   glog_if[$];
    int   glog_cnt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_tab(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return a ^ 32'h5555_0000;
    endfunction

    // Memory model: acks in the mem_lat-th cycle of mem_req; manual drive when mem_en is 0.
    int          mem_lat   = 1;
    bit          mem_en    = 1'b1;
    logic        mdl_ack   = 1'b0;
    logic        man_ack   = 1'b0;
    logic [31:0] mdl_rdata = 32'h0;
    logic [31:0] man_rdata = 32'h0;

    assign mem_ack   = mem_en ? mdl_ack   : man_ack;
    assign mem_rdata = mem_en ? mdl_rdata : man_rdata;

    initial begin : mem_model
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                cyc++;
                mdl_ack   = (cyc == mem_lat);
                mdl_rdata = mdl_ack ? rd_tab(mem_addr) : 32'h0BAD_0000;
            end else begin
                cyc     = 0;
                mdl_ack = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic prev_req;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                glog_if.push_back(mem_addr == 32'h100);
                glog_cnt.push_back(int'(u_dut.u_starve.starve_cnt));
            end
            prev_req = mem_req;
            if (if_ready || dm_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ready", {30'b0, if_ready, dm_ready}, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ready_port_is_if", {31'b0, if_ready}, {31'b0, e.is_if});
                    chk("ready_rdata", if_ready ? if_rdata : dm_rdata, e.data);
                end
            end
        end
    end

    // Requests must stay high until the cycle after their ready pulse.
    logic p_if = 1'b0, p_dm = 1'b0, p_ifr = 1'b0, p_dmr = 1'b0;
    always @(posedge clk) begin
        if (!reset_b) begin
            assert (!(p_if && !if_req && !p_ifr)) else $error("if_req dropped without if_ready");
            assert (!(p_dm && !dm_req && !p_dmr)) else $error("dm_req dropped without dm_ready");
        end
        p_if  <= if_req;
        p_dm  <= dm_req;
        p_ifr <= if_ready;
        p_dmr <= dm_ready;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ready(input bit is_if, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = is_if ? if_ready : dm_ready;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: got no ready expected ready within 100 cycles", name);
        end
    endtask

    task automatic txn(input bit is_if, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input int lat, input string name);
        mem_lat = lat;
        sb_q.push_back('{is_if, exp_data});
        @(posedge clk); #1;
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            dm_req   = 1'b1;
            dm_we    = we;
            dm_addr  = addr;
            dm_wdata = wdata;
        end
        wait_ready(is_if, name);
        @(posedge clk); #1;
        if (is_if) if_req = 1'b0;
        else       dm_req = 1'b0;
    endtask

    initial begin : stimulus
        bit exp_if  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int exp_cnt [7] = '{1, 2, 0, 1, 2, 0, 0};
        int n;
        int busy;
        bit seen;

        reset_b  = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req",  {31'b0, mem_req},  32'h0);
        chk("rst_mem_we",   {31'b0, mem_we},   32'h0);
        chk("rst_mem_addr", mem_addr,          32'h0);
        chk("rst_if_ready", {31'b0, if_ready}, 32'h0);
        chk("rst_dm_ready", {31'b0, dm_ready}, 32'h0);
        chk("rst_if_rdata", if_rdata,          32'h0);
        chk("rst_dm_rdata", dm_rdata,          32'h0);
        @(posedge clk); #1;
        reset_b = 1'b0;

        // IF-only read against zero-wait memory, cycle by cycle.
        mem_lat = 1;
        sb_q.push_back('{1'b1, 32'h2008_0005});
        @(posedge clk); #1;
        if_req  = 1'b1;
        if_addr = 32'h0040_0000;
        @(negedge clk);
        chk("if_c0_mem_req",  {31'b0, mem_req},  32'h0);
        chk("if_c0_stall",    {31'b0, if_stall}, 32'h1);
        @(negedge clk);
        chk("if_c1_mem_req",  {31'b0, mem_req},  32'h1);
        chk("if_c1_mem_addr", mem_addr,          32'h0040_0000);
        chk("if_c1_mem_we",   {31'b0, mem_we},   32'h0);
        chk("if_c1_ready",    {31'b0, if_ready}, 32'h0);
        @(negedge clk);
        chk("if_c2_ready",    {31'b0, if_ready}, 32'h1);
        chk("if_c2_rdata",    if_rdata,          32'h2008_0005);
        chk("if_c2_stall",    {31'b0, if_stall}, 32'h0);
        chk("if_c2_mem_req",  {31'b0, mem_req},  32'h0);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("if_c3_rdata_held", if_rdata, 32'h2008_0005);

        // Contention with both requests held: D, D, I, D, D, I, then a lone D.
        glog_if.delete();
        glog_cnt.delete();
        mem_lat = 1;
        for (int i = 0; i < 7; i++) begin
            sb_q.push_back('{exp_if[i], exp_if[i] ? 32'h5555_0100 : 32'h5555_0200});
        end
        @(posedge clk); #1;
        if_addr = 32'h100;
        dm_addr = 32'h200;
        dm_we   = 1'b0;
        if_req  = 1'b1;
        dm_req  = 1'b1;
        n = 0;
        for (int i = 0; i < 300 && n < 6; i++) begin
            @(negedge clk);
            if (if_ready || dm_ready) n++;
        end
        chk("contention_served", n, 6);
        @(posedge clk); #1;
        if_req = 1'b0;
        wait_ready(1'b0, "contention_tail");
        @(posedge clk); #1;
        dm_req = 1'b0;
        chk("gnt_log_size", glog_if.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < glog_if.size()) begin
                chk($sformatf("gnt_order_%0d", i), {31'b0, glog_if[i]}, {31'b0, exp_if[i]});
                chk($sformatf("starve_cnt_%0d", i), glog_cnt[i], exp_cnt[i]);
            end
        end

        // Store with 3-cycle memory: command held stable, dm_rdata untouched.
        mem_lat = 3;
        sb_q.push_back('{1'b0, 32'h5555_0200});
        @(posedge clk); #1;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0010;
        dm_wdata = 32'hDEAD_BEEF;
        busy = 0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) begin
                busy++;
                chk("st_mem_we",    {31'b0, mem_we}, 32'h1);
                chk("st_mem_addr",  mem_addr,        32'h0000_0010);
                chk("st_mem_wdata", mem_wdata,       32'hDEAD_BEEF);
            end
            seen = dm_ready;
        end
        chk("st_busy_cycles", busy, 3);
        chk("st_dm_rdata", dm_rdata, 32'h5555_0200);
        @(posedge clk); #1;
        dm_req = 1'b0;
        dm_we  = 1'b0;

        // Spurious ack while idle.
        mem_en = 1'b0;
        @(posedge clk); #1;
        man_rdata = 32'hFFFF_FFFF;
        man_ack   = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("spur_if_rdata", if_rdata, 32'h5555_0100);
        chk("spur_dm_rdata", dm_rdata, 32'h5555_0200);

        // Reset in the middle of a data load, then a late ack.
        @(posedge clk); #1;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h300;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req;
        end
        chk("rb_mem_req_seen", {31'b0, seen}, 32'h1);
        @(posedge clk); #1;
        reset_b = 1'b1;
        dm_req  = 1'b0;
        @(posedge clk); #1;
        reset_b = 1'b0;
        @(negedge clk);
        chk("rb_mem_req_low", {31'b0, mem_req}, 32'h0);
        @(posedge clk); #1;
        man_rdata = 32'hBAD0_BAD0;
        man_ack   = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rb_dm_rdata", dm_rdata, 32'h0);
        chk("rb_if_rdata", if_rdata, 32'h0);
        mem_en = 1'b1;
        txn(1'b1, 1'b0, 32'h0040_0000, 32'h0, 32'h2008_0005, 1, "if_after_reset");

        // Since reset: 4 I grants, 3 D grants, 0+1+0+2+1+1 = 5 wait cycles.
        txn(1'b1, 1'b0, 32'h100, 32'h0,         32'h5555_0100, 1, "perf_i1");
        txn(1'b1, 1'b0, 32'h104, 32'h0,         32'h5555_0104, 2, "perf_i2");
        txn(1'b1, 1'b0, 32'h108, 32'h0,         32'h5555_0108, 1, "perf_i3");
        txn(1'b0, 1'b0, 32'h200, 32'h0,         32'h5555_0200, 3, "perf_d1");
        txn(1'b0, 1'b1, 32'h204, 32'h1234_5678, 32'h5555_0200, 2, "perf_d2");
        txn(1'b0, 1'b0, 32'h208, 32'h0,         32'h5555_0208, 2, "perf_d3");
        repeat (2) @(negedge clk);
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_if_grants",   perf_if_grants,   32'd4);
        chk("perf_dm_grants",   perf_dm_grants,   32'd3);
        chk("perf_wait_cycles", perf_wait_cycles, 32'd5);
`endif
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
